// File: rtl/rf_write_arbiter.sv
// Two-source writeback arbiter for the decode-stage register file write port.
// Each source parks one write in a holding slot; round-robin picks one per cycle.
module rf_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [IDX_W-1:0]  a_idx,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [IDX_W-1:0]  b_idx,
   input  logic [DATA_W-1:0] b_data,
   output logic [IDX_W-1:0]  write_idx,
   output logic [DATA_W-1:0] write_data,
   output logic              rwrite,
   output logic [CNT_W-1:0]  conflict_cnt,
   output logic              busy
);

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   logic              pend_a_q, pend_a_d;
   logic              pend_b_q, pend_b_d;
   logic [IDX_W-1:0]  idx_a_q, idx_a_d;
   logic [IDX_W-1:0]  idx_b_q, idx_b_d;
   logic [DATA_W-1:0] data_a_q, data_a_d;
   logic [DATA_W-1:0] data_b_q, data_b_d;
   src_e              last_q, last_d;
   logic              rwrite_q, rwrite_d;
   logic [IDX_W-1:0]  write_idx_q, write_idx_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              grant_a, grant_b;
   logic              acc_a, acc_b;
   logic [IDX_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] gnt_data;

   // Grant looks only at the slots, so ready never depends on valid.
   always_comb begin
      grant_a = pend_a_q & (!pend_b_q | (last_q == SRC_B));
      grant_b = pend_b_q & (!pend_a_q | (last_q == SRC_A));
   end

   assign a_ready = !pend_a_q | grant_a;
   assign b_ready = !pend_b_q | grant_b;
   assign acc_a   = a_valid & a_ready;
   assign acc_b   = b_valid & b_ready;

   assign gnt_idx  = grant_a ? idx_a_q  : idx_b_q;
   assign gnt_data = grant_a ? data_a_q : data_b_q;

   always_comb begin
      pend_a_d     = pend_a_q;
      pend_b_d     = pend_b_q;
      idx_a_d      = idx_a_q;
      idx_b_d      = idx_b_q;
      data_a_d     = data_a_q;
      data_b_d     = data_b_q;
      last_d       = last_q;
      rwrite_d     = 1'b0;
      write_idx_d  = write_idx_q;
      write_data_d = write_data_q;
      cnt_d        = cnt_q;

      if (grant_a) begin
         pend_a_d = 1'b0;
         last_d   = SRC_A;
      end
      if (grant_b) begin
         pend_b_d = 1'b0;
         last_d   = SRC_B;
      end

      // A refill at the same edge as the grant keeps the slot occupied.
      if (acc_a) begin
         pend_a_d = 1'b1;
         idx_a_d  = a_idx;
         data_a_d = a_data;
      end
      if (acc_b) begin
         pend_b_d = 1'b1;
         idx_b_d  = b_idx;
         data_b_d = b_data;
      end

      // Writes to register 0 consume the grant but never reach the file.
      if ((grant_a | grant_b) && (gnt_idx != '0)) begin
         rwrite_d     = 1'b1;
         write_idx_d  = gnt_idx;
         write_data_d = gnt_data;
      end

      if (pend_a_q & pend_b_q && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_a_q     <= 1'b0;
         pend_b_q     <= 1'b0;
         idx_a_q      <= '0;
         idx_b_q      <= '0;
         data_a_q     <= '0;
         data_b_q     <= '0;
         last_q       <= SRC_B;
         rwrite_q     <= 1'b0;
         write_idx_q  <= '0;
         write_data_q <= '0;
         cnt_q        <= '0;
      end else begin
         pend_a_q     <= pend_a_d;
         pend_b_q     <= pend_b_d;
         idx_a_q      <= idx_a_d;
         idx_b_q      <= idx_b_d;
         data_a_q     <= data_a_d;
         data_b_q     <= data_b_d;
         last_q       <= last_d;
         rwrite_q     <= rwrite_d;
         write_idx_q  <= write_idx_d;
         write_data_q <= write_data_d;
         cnt_q        <= cnt_d;
      end
   end

   assign rwrite       = rwrite_q;
   assign write_idx    = write_idx_q;
   assign write_data   = write_data_q;
   assign conflict_cnt = cnt_q;
   assign busy         = pend_a_q | pend_b_q | rwrite_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: expected writes queued in grant order,
// popped and compared whenever the register file write strobe fires.
module tb_rf_write_arbiter;

   localparam int DW = 32;
   localparam int IW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid, b_valid;
   logic          a_ready, b_ready;
   logic [IW-1:0] a_idx, b_idx;
   logic [DW-1:0] a_data, b_data;
   logic [IW-1:0] write_idx;
   logic [DW-1:0] write_data;
   logic          rwrite;
   logic [CW-1:0] conflict_cnt;
   logic          busy;

   int n_chk = 0;
   int n_pass = 0;

   logic [IW+DW-1:0] exp_q[$];
   logic [DW-1:0]    shadow [32];

   rf_write_arbiter #(
      .DATA_W(DW),
      .IDX_W (IW),
      .CNT_W (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_idx       (a_idx),
      .a_data      (a_data),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_idx       (b_idx),
      .b_data      (b_data),
      .write_idx   (write_idx),
      .write_data  (write_data),
      .rwrite      (rwrite),
      .conflict_cnt(conflict_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
   endtask

   task automatic push_exp(input logic [IW-1:0] i, input logic [DW-1:0] d);
      exp_q.push_back({i, d});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write monitor: every strobe must match the next queued write.
   always @(negedge clk) begin
      if (rst_n && rwrite) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(write_idx), 32'hFFFF_FFFF);
         end else begin
            logic [IW+DW-1:0] e;
            e = exp_q.pop_front();
            chk("wr_idx", 32'(write_idx), 32'(e[IW+DW-1:DW]));
            chk("wr_data", write_data, e[DW-1:0]);
         end
         shadow[write_idx] = write_data;
      end
   end

   task automatic do_reset();
      rst_n   = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_idx   = '0;
      b_idx   = '0;
      a_data  = '0;
      b_data  = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int ia, ib;
      logic fa, fb;
      int exp_c;

      do_reset();
      chk("rst_rwrite", 32'(rwrite), 0);
      chk("rst_widx", 32'(write_idx), 0);
      chk("rst_wdata", write_data, 0);
      chk("rst_cnt", 32'(conflict_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_a_ready", 32'(a_ready), 1);
      chk("rst_b_ready", 32'(b_ready), 1);

      // Single write from A
      a_valid = 1'b1; a_idx = 5'd1; a_data = 32'hDEAD_BEEF;
      push_exp(5'd1, 32'hDEAD_BEEF);
      chk("t1_a_ready", 32'(a_ready), 1);
      step();
      a_valid = 1'b0;
      chk("t1_c1_rwrite", 32'(rwrite), 0);
      chk("t1_c1_busy", 32'(busy), 1);
      step();
      chk("t1_c2_rwrite", 32'(rwrite), 1);
      chk("t1_c2_widx", 32'(write_idx), 1);
      chk("t1_c2_wdata", write_data, 32'hDEAD_BEEF);
      step();
      chk("t1_c3_rwrite", 32'(rwrite), 0);
      chk("t1_c3_busy", 32'(busy), 0);

      // Register zero: handshake completes, nothing written
      a_valid = 1'b1; a_idx = 5'd0; a_data = 32'hFFFF_FFFF;
      chk("r0_a_ready", 32'(a_ready), 1);
      step();
      a_valid = 1'b0;
      chk("r0_c1_busy", 32'(busy), 1);
      for (int c = 2; c <= 3; c++) begin
         step();
         chk("r0_rwrite", 32'(rwrite), 0);
         chk("r0_widx", 32'(write_idx), 1);
         chk("r0_wdata", write_data, 32'hDEAD_BEEF);
      end
      chk("r0_busy", 32'(busy), 0);

      // Simultaneous writes after reset: A first
      do_reset();
      a_valid = 1'b1; a_idx = 5'd2; a_data = 32'hCAFE_BABE;
      b_valid = 1'b1; b_idx = 5'd3; b_data = 32'hDEAD_C0DE;
      push_exp(5'd2, 32'hCAFE_BABE);
      push_exp(5'd3, 32'hDEAD_C0DE);
      chk("t2_c0_b_ready", 32'(b_ready), 1);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      chk("t2_c1_b_ready", 32'(b_ready), 0);
      chk("t2_c1_a_ready", 32'(a_ready), 1);
      step();
      chk("t2_c2_rwrite", 32'(rwrite), 1);
      chk("t2_c2_widx", 32'(write_idx), 2);
      chk("t2_c2_b_ready", 32'(b_ready), 1);
      chk("t2_c2_cnt", 32'(conflict_cnt), 1);
      step();
      chk("t2_c3_widx", 32'(write_idx), 3);
      step();
      chk("t2_c4_rwrite", 32'(rwrite), 0);
      chk("t2_c4_busy", 32'(busy), 0);
      chk("t2_c4_cnt", 32'(conflict_cnt), 1);

      // Same index on both after a B grant: A then B, B wins
      a_valid = 1'b1; a_idx = 5'd2; a_data = 32'h1111_1111;
      b_valid = 1'b1; b_idx = 5'd2; b_data = 32'h2222_2222;
      push_exp(5'd2, 32'h1111_1111);
      push_exp(5'd2, 32'h2222_2222);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (4) step();
      chk("t3_reg2", shadow[2], 32'h2222_2222);
      chk("t3_q_empty", 32'(exp_q.size()), 0);

      // B streams alone for 8 cycles
      do_reset();
      for (int k = 0; k < 8; k++) begin
         b_valid = 1'b1;
         b_idx   = IW'(k + 1);
         b_data  = 32'hB000_0000 + 32'(k);
         push_exp(IW'(k + 1), 32'hB000_0000 + 32'(k));
         chk("t4_b_ready", 32'(b_ready), 1);
         step();
      end
      b_valid = 1'b0;
      repeat (3) step();
      chk("t4_q_empty", 32'(exp_q.size()), 0);
      chk("t4_cnt", 32'(conflict_cnt), 0);

      // Both stream: strict A/B alternation, A first
      for (int k = 0; k < 8; k++) begin
         push_exp(IW'(10 + k), 32'hA000_0000 + 32'(k));
         push_exp(IW'(20 + k), 32'hB100_0000 + 32'(k));
      end
      ia = 0;
      ib = 0;
      for (int c = 0; c < 20; c++) begin
         exp_c = (c == 0) ? 0 : ((c - 1 > 15) ? 15 : c - 1);
         chk("t5_cnt", 32'(conflict_cnt), 32'(exp_c));
         a_valid = (ia < 8);
         a_idx   = IW'(10 + ia);
         a_data  = 32'hA000_0000 + 32'(ia);
         b_valid = (ib < 8);
         b_idx   = IW'(20 + ib);
         b_data  = 32'hB100_0000 + 32'(ib);
         @(negedge clk);
         fa = a_valid & a_ready;
         fb = b_valid & b_ready;
         step();
         if (fa) ia++;
         if (fb) ib++;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      chk("t5_q_empty", 32'(exp_q.size()), 0);

      // Saturation: both parked on register 0 forever
      do_reset();
      a_valid = 1'b1; a_idx = 5'd0; a_data = 32'h0;
      b_valid = 1'b1; b_idx = 5'd0; b_data = 32'h0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 10) chk("sat_cnt_mid", 32'(conflict_cnt), 9);
      end
      chk("sat_cnt", 32'(conflict_cnt), 15);
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (3) step();
      chk("sat_hold", 32'(conflict_cnt), 15);

      // Reset with entries pending: dropped, no write after release
      a_valid = 1'b1; a_idx = 5'd5; a_data = 32'h5555_5555;
      b_valid = 1'b1; b_idx = 5'd6; b_data = 32'h6666_6666;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mr_rwrite", 32'(rwrite), 0);
      chk("mr_widx", 32'(write_idx), 0);
      chk("mr_wdata", write_data, 0);
      chk("mr_cnt", 32'(conflict_cnt), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_a_ready", 32'(a_ready), 1);
      chk("mr_b_ready", 32'(b_ready), 1);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("mr_no_write", 32'(rwrite), 0);
         chk("mr_idle", 32'(busy), 0);
      end
      chk("end_q_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
